// File: rtl/poly_arith_pkg.sv
// ============================================================================
// poly_arith_pkg : shared ML-KEM coefficient types and reduction constants
// Rev 1.0
// ============================================================================
`default_nettype none

package poly_arith_pkg;

  typedef logic [11:0] coeff_t;
  typedef logic [23:0] prod_t;

  localparam coeff_t      Q             = 12'd3329;
  localparam int unsigned BARRETT_M     = 5039;
  localparam int unsigned BARRETT_SHIFT = 24;

endpackage

`default_nettype wire

// File: rtl/barrett_reduce.sv
// ============================================================================
// barrett_reduce : combinational 24-bit -> coeff_t reduction mod Q
// Rev 1.0
// ============================================================================
`default_nettype none

module barrett_reduce
  import poly_arith_pkg::*;
(
  input  logic [23:0] x,
  output logic [11:0] r
);

  logic [12:0] t;
  logic [23:0] tq;
  logic [12:0] rem;

  // The quotient estimate undershoots by at most one, so rem < 2Q.
  assign t   = 13'(({13'd0, x} * 37'(BARRETT_M)) >> BARRETT_SHIFT);
  assign tq  = {11'd0, t} * {12'd0, Q};
  assign rem = 13'(x - tq);
  assign r   = (rem >= {1'b0, Q}) ? 12'(rem - {1'b0, Q}) : rem[11:0];

endmodule

`default_nettype wire

// File: rtl/mod_div_by_2.sv
// ============================================================================
// mod_div_by_2 : multiply a coefficient by 2^-1 mod Q
// Rev 1.0
// ============================================================================
`default_nettype none

module mod_div_by_2
  import poly_arith_pkg::*;
(
  input  logic [11:0] x,
  output logic [11:0] y
);

  logic [12:0] s;

  // Odd values become even by adding Q, then an exact halving.
  assign s = x[0] ? ({1'b0, x} + {1'b0, Q}) : {1'b0, x};
  assign y = 12'(s >> 1);

endmodule

`default_nettype wire

// File: rtl/intt_gs_butterfly.sv
// ============================================================================
// intt_gs_butterfly : 3-stage Gentleman-Sande butterfly for the ML-KEM INTT
// Rev 1.0
// ============================================================================
`default_nettype none

module intt_gs_butterfly
  import poly_arith_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [11:0] a_i,
  input  logic [11:0] b_i,
  input  logic [11:0] zeta_i,
  input  logic        half_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [11:0] a_o,
  output logic [11:0] b_o
);

  logic        adv;

  logic [12:0] sum_full;
  logic [11:0] sum_next;
  logic [11:0] diff_next;

  logic        s1_valid;
  logic [11:0] s1_sum;
  logic [11:0] s1_diff;
  logic [11:0] s1_zeta;
  logic        s1_half;

  logic        s2_valid;
  logic [23:0] s2_prod;
  logic [11:0] s2_sum;
  logic        s2_half;

  logic [11:0] red;
  logic [11:0] sum_halved;
  logic [11:0] red_halved;

  // Whole pipeline moves as one; a held output freezes every stage.
  assign adv        = !out_valid_o || out_ready_i;
  assign in_ready_o = adv;

  assign sum_full  = {1'b0, a_i} + {1'b0, b_i};
  assign sum_next  = (sum_full >= {1'b0, Q}) ? 12'(sum_full - {1'b0, Q}) : sum_full[11:0];
  assign diff_next = (b_i >= a_i) ? (b_i - a_i) : 12'({1'b0, b_i} + {1'b0, Q} - {1'b0, a_i});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_diff  <= '0;
      s1_zeta  <= '0;
      s1_half  <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid_i;
      s1_sum   <= sum_next;
      s1_diff  <= diff_next;
      s1_zeta  <= zeta_i;
      s1_half  <= half_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_prod  <= '0;
      s2_sum   <= '0;
      s2_half  <= 1'b0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_prod  <= {12'd0, s1_diff} * {12'd0, s1_zeta};
      s2_sum   <= s1_sum;
      s2_half  <= s1_half;
    end
  end

  barrett_reduce u_barrett (
    .x (s2_prod),
    .r (red)
  );

  mod_div_by_2 u_half_sum (
    .x (s2_sum),
    .y (sum_halved)
  );

  mod_div_by_2 u_half_red (
    .x (red),
    .y (red_halved)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_o <= 1'b0;
      a_o         <= '0;
      b_o         <= '0;
    end else if (adv) begin
      out_valid_o <= s2_valid;
      a_o         <= s2_half ? sum_halved : s2_sum;
      b_o         <= s2_half ? red_halved : red;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_intt_gs_butterfly.sv
// ============================================================================
// tb_intt_gs_butterfly : directed and random checks against an arithmetic model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_intt_gs_butterfly;

  localparam int QM = 3329;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [11:0] a_i = '0;
  logic [11:0] b_i = '0;
  logic [11:0] zeta_i = '0;
  logic        half_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [11:0] a_o;
  logic [11:0] b_o;

  intt_gs_butterfly dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .zeta_i      (zeta_i),
    .half_i      (half_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .a_o         (a_o),
    .b_o         (b_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int z;
    bit h;
    bit dir;
    int ea;
    int eb;
  } txn_t;

  txn_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int in_cnt   = 0;
  int out_cnt  = 0;
  int ready_mode = 0;   // 0 always ready, 1 random, 2 never ready

  bit cur_dir = 1'b0;
  int cur_ea  = 0;
  int cur_eb  = 0;

  bit          prev_stall = 1'b0;
  logic [11:0] prev_a;
  logic [11:0] prev_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int mod_q(input int x);
    int m;
    m = x % QM;
    if (m < 0) m += QM;
    return m;
  endfunction

  // Reference: the butterfly written directly from its arithmetic definition.
  function automatic void golden(input int a, input int b, input int z, input bit h,
                                 output int ea, output int eb);
    ea = mod_q(a + b);
    eb = mod_q(z * (b - a + QM));
    if (h) begin
      ea = mod_q(ea * 1665);
      eb = mod_q(eb * 1665);
    end
  endfunction

  // Monitor: inputs only change just after a rising edge, so the values seen
  // here are exactly those present at the next rising edge.
  always @(negedge clk) begin
    txn_t t;
    txn_t e;
    int ga;
    int gb;
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", out_valid_o, 1);
        check("stall_a", a_o, prev_a);
        check("stall_b", b_o, prev_b);
      end
      if (out_valid_o && out_ready_i) begin
        out_cnt++;
        check("out_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          golden(e.a, e.b, e.z, e.h, ga, gb);
          check("a_model", a_o, ga);
          check("b_model", b_o, gb);
          if (e.dir) begin
            check("a_directed", a_o, e.ea);
            check("b_directed", b_o, e.eb);
          end
        end
      end
      if (in_valid_i && in_ready_o) begin
        in_cnt++;
        t.a = int'(a_i);
        t.b = int'(b_i);
        t.z = int'(zeta_i);
        t.h = half_i;
        t.dir = cur_dir;
        t.ea = cur_ea;
        t.eb = cur_eb;
        exp_q.push_back(t);
      end
      prev_stall = out_valid_o && !out_ready_i;
      prev_a = a_o;
      prev_b = b_o;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready_i = 1'b1;
        1:       out_ready_i = ($urandom_range(0, 9) < 7);
        default: out_ready_i = 1'b0;
      endcase
    end
  end

  task automatic send(input int a, input int b, input int z, input bit h,
                      input bit dir, input int ea, input int eb);
    int  waited;
    bit  done;
    waited     = 0;
    done       = 1'b0;
    a_i        = 12'(a);
    b_i        = 12'(b);
    zeta_i     = 12'(z);
    half_i     = h;
    cur_dir    = dir;
    cur_ea     = ea;
    cur_eb     = eb;
    in_valid_i = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready_o) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 200) begin
          check("send_timeout", 1, 0);
          done = 1'b1;
        end
      end
    end
    in_valid_i = 1'b0;
    cur_dir    = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    ready_mode = 0;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int ra;
    int rb;
    int rz;
    bit rh;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_a_o", a_o, 0);
    check("rst_b_o", b_o, 0);
    check("rst_in_ready", in_ready_o, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed vectors
    send(0, 0, 17, 1'b0, 1'b1, 0, 0);
    send(1, 3328, 17, 1'b0, 1'b1, 0, 3295);
    send(3, 5, 1, 1'b1, 1'b1, 4, 1);
    send(5, 3, 1, 1'b1, 1'b1, 4, 3328);
    send(3328, 3328, 3328, 1'b0, 1'b1, 3327, 0);
    send(0, 1, 3328, 1'b0, 1'b1, 1, 3328);
    drain();

    // Backpressure: five offered, three accepted while output is held
    ready_mode = 2;
    @(posedge clk);
    #2;
    base = in_cnt;
    fork
      begin
        send(10, 20, 30, 1'b0, 1'b0, 0, 0);
        send(3000, 400, 55, 1'b1, 1'b0, 0, 0);
        send(7, 3320, 2000, 1'b0, 1'b0, 0, 0);
        send(1234, 1234, 999, 1'b1, 1'b0, 0, 0);
        send(3328, 0, 1, 1'b0, 1'b0, 0, 0);
      end
      begin
        repeat (7) @(negedge clk);
        #1;
        check("bp_in_ready", in_ready_o, 0);
        check("bp_out_valid", out_valid_o, 1);
        check("bp_accepted", in_cnt - base, 3);
        ready_mode = 0;
      end
    join
    drain();
    check("bp_all_accepted", in_cnt - base, 5);

    // Mid-stream reset with a full pipeline
    ready_mode = 2;
    @(posedge clk);
    #1;
    send(100, 200, 300, 1'b0, 1'b0, 0, 0);
    send(400, 500, 600, 1'b1, 1'b0, 0, 0);
    send(700, 800, 900, 1'b0, 1'b0, 0, 0);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid_o, 0);
    check("midrst_a_o", a_o, 0);
    check("midrst_b_o", b_o, 0);
    check("midrst_in_ready", in_ready_o, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ready_mode = 0;
    base = out_cnt;
    idle(10);
    check("post_reset_quiet", out_cnt - base, 0);

    // Random stress with random valid gaps and ready toggling
    ready_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom_range(0, QM - 1);
      rb = $urandom_range(0, QM - 1);
      rz = $urandom_range(0, QM - 1);
      rh = $urandom_range(0, 1);
      send(ra, rb, rz, rh, 1'b0, 0, 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain();
    check("total_io", out_cnt, in_cnt - 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
